// File: rtl/alu_rs.sv
// alu_rs: compacting age-ordered reservation station feeding the master ALU
module alu_rs #(
  parameter int DEPTH   = 4,
  parameter int OP_W    = 6,
  parameter int WORD_W  = 32,
  parameter int TAG_W   = 2,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               issue_en,
  input  logic [OP_W-1:0]    issue_op,
  input  logic [WORD_W-1:0]  issue_datax,
  input  logic [TAG_W-1:0]   issue_tagx,
  input  logic [WORD_W-1:0]  issue_datay,
  input  logic [TAG_W-1:0]   issue_tagy,
  input  logic [RADDR_W-1:0] issue_rd,
  output logic               full,
  input  logic               en_w0,
  input  logic [WORD_W-1:0]  write_data0,
  input  logic               en_w1,
  input  logic [WORD_W-1:0]  write_data1,
  input  logic               en_wM,
  input  logic [WORD_W-1:0]  write_dataM,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [OP_W-1:0]    ex_op,
  output logic [WORD_W-1:0]  ex_a,
  output logic [WORD_W-1:0]  ex_b,
  output logic [RADDR_W-1:0] ex_rd
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NT = 2 ** TAG_W;
  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [RADDR_W-1:0] rd;
    logic [WORD_W-1:0]  vx;
    logic [TAG_W-1:0]   tx;
    logic [WORD_W-1:0]  vy;
    logic [TAG_W-1:0]   ty;
  } ent_t;
  ent_t q [DEPTH];
  ent_t w [DEPTH];
  ent_t nq [DEPTH];
  ent_t ne;
  logic [CW-1:0] count, c1, sel;
  logic [NT-1:0] hit;
  logic [WORD_W-1:0] bd [NT];
  logic found, fire, acc;
  always_comb begin
    hit = '0;
    hit[1] = en_w0;
    hit[2] = en_w1;
    hit[3] = en_wM;
    for (int i = 0; i < NT; i++) bd[i] = '0;
    bd[1] = write_data0;
    bd[2] = write_data1;
    bd[3] = write_dataM;
  end
  // tag 0 never hits, so ready operands keep their stored value
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = q[i];
      if (hit[q[i].tx]) begin
        w[i].vx = bd[q[i].tx];
        w[i].tx = '0;
      end
      if (hit[q[i].ty]) begin
        w[i].vy = bd[q[i].ty];
        w[i].ty = '0;
      end
    end
    ne.op = issue_op;
    ne.rd = issue_rd;
    ne.vx = hit[issue_tagx] ? bd[issue_tagx] : issue_datax;
    ne.tx = hit[issue_tagx] ? '0 : issue_tagx;
    ne.vy = hit[issue_tagy] ? bd[issue_tagy] : issue_datay;
    ne.ty = hit[issue_tagy] ? '0 : issue_tagy;
  end
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!found && CW'(i) < count && q[i].tx == '0 && q[i].ty == '0) begin
        found = 1'b1;
        sel = CW'(i);
      end
  end
  assign ex_valid = rdy && found;
  assign fire = ex_valid && ex_ready;
  assign acc = rdy && issue_en && count < CW'(DEPTH);
  assign c1 = count - CW'(fire);
  assign full = count == CW'(DEPTH);
  assign ex_op = ex_valid ? q[sel].op : '0;
  assign ex_a = ex_valid ? q[sel].vx : '0;
  assign ex_b = ex_valid ? q[sel].vy : '0;
  assign ex_rd = ex_valid ? q[sel].rd : '0;
  // slots at or above the dispatched one move down; the new op lands after compaction
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) nq[i] = (fire && CW'(i) >= sel) ? w[i+1] : w[i];
    nq[DEPTH-1] = w[DEPTH-1];
    if (acc) nq[c1] = ne;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (rdy) begin
      count <= c1 + CW'(acc);
      q <= nq;
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed self-checking bench for alu_rs
module tb_alu_rs;
  logic clk = 0, rst, rdy, issue_en, full, en_w0, en_w1, en_wM, ex_valid, ex_ready;
  logic [5:0] issue_op, ex_op;
  logic [31:0] issue_datax, issue_datay, write_data0, write_data1, write_dataM, ex_a, ex_b;
  logic [1:0] issue_tagx, issue_tagy;
  logic [4:0] issue_rd, ex_rd;
  int checks = 0, errors = 0;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .issue_en(issue_en), .issue_op(issue_op),
    .issue_datax(issue_datax), .issue_tagx(issue_tagx), .issue_datay(issue_datay),
    .issue_tagy(issue_tagy), .issue_rd(issue_rd), .full(full),
    .en_w0(en_w0), .write_data0(write_data0), .en_w1(en_w1), .write_data1(write_data1),
    .en_wM(en_wM), .write_dataM(write_dataM), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [1:0] tx, input logic [31:0] dx,
                       input logic [1:0] ty, input logic [31:0] dy, input logic [4:0] rd);
    issue_en = 1; issue_op = op; issue_tagx = tx; issue_datax = dx;
    issue_tagy = ty; issue_datay = dy; issue_rd = rd;
  endtask

  initial begin
    rst = 1; rdy = 1; issue_en = 0; issue_op = 0; issue_datax = 0; issue_tagx = 0;
    issue_datay = 0; issue_tagy = 0; issue_rd = 0; en_w0 = 0; en_w1 = 0; en_wM = 0;
    write_data0 = 0; write_data1 = 0; write_dataM = 0; ex_ready = 0;
    tick;
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_ex_a", ex_a, 0);
    chk("rst_count", 32'(dut.count), 0);
    rst = 0;
    // ready issue
    ex_ready = 1;
    issue(6'h01, 0, 5, 0, 7, 3);
    tick; issue_en = 0;
    chk("ri_valid", 32'(ex_valid), 1);
    chk("ri_op", 32'(ex_op), 1);
    chk("ri_a", ex_a, 5);
    chk("ri_b", ex_b, 7);
    chk("ri_rd", 32'(ex_rd), 3);
    tick;
    chk("ri_gone", 32'(ex_valid), 0);
    chk("ri_count", 32'(dut.count), 0);
    // wake-up from load/store bus
    issue(6'h02, 3, 0, 0, 9, 4);
    tick; issue_en = 0;
    chk("wk_wait1", 32'(ex_valid), 0);
    tick;
    chk("wk_wait2", 32'(ex_valid), 0);
    en_wM = 1; write_dataM = 32'h1234;
    #1 chk("wk_bcast_cycle", 32'(ex_valid), 0);
    tick; en_wM = 0;
    chk("wk_valid", 32'(ex_valid), 1);
    chk("wk_a", ex_a, 32'h1234);
    chk("wk_b", ex_b, 9);
    tick;
    chk("wk_count", 32'(dut.count), 0);
    // same-cycle bypass from ALU master
    issue(6'h03, 1, 0, 0, 1, 5);
    en_w0 = 1; write_data0 = 42;
    tick; issue_en = 0; en_w0 = 0;
    chk("bp_valid", 32'(ex_valid), 1);
    chk("bp_a", ex_a, 42);
    tick;
    chk("bp_count", 32'(dut.count), 0);
    // out-of-order dispatch
    issue(6'h04, 2, 0, 0, 2, 1);
    tick;
    chk("oo_a_pending", 32'(ex_valid), 0);
    issue(6'h05, 0, 10, 0, 11, 2);
    tick; issue_en = 0;
    chk("oo_b_valid", 32'(ex_valid), 1);
    chk("oo_b_rd", 32'(ex_rd), 2);
    chk("oo_b_a", ex_a, 10);
    tick;
    chk("oo_after_b", 32'(ex_valid), 0);
    chk("oo_count1", 32'(dut.count), 1);
    en_w1 = 1; write_data1 = 8;
    tick; en_w1 = 0;
    chk("oo_a_valid", 32'(ex_valid), 1);
    chk("oo_a_val", ex_a, 8);
    chk("oo_a_rd", 32'(ex_rd), 1);
    tick;
    chk("oo_count0", 32'(dut.count), 0);
    // fill under backpressure
    ex_ready = 0;
    for (int k = 0; k < 4; k++) begin
      issue(6'h06, 0, 100 + k, 0, 0, 5'(4 + k));
      tick;
    end
    chk("fl_full", 32'(full), 1);
    chk("fl_count", 32'(dut.count), 4);
    issue(6'h07, 0, 200, 0, 0, 9);
    tick; issue_en = 0;
    chk("fl_drop_count", 32'(dut.count), 4);
    chk("fl_head_rd", 32'(ex_rd), 4);
    ex_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("fl_drain_valid", 32'(ex_valid), 1);
      chk("fl_drain_rd", 32'(ex_rd), 32'(4 + k));
      chk("fl_drain_a", ex_a, 32'(100 + k));
      tick;
      if (k == 0) chk("fl_unfull", 32'(full), 0);
    end
    chk("fl_empty_valid", 32'(ex_valid), 0);
    chk("fl_empty_count", 32'(dut.count), 0);
    // simultaneous issue and dispatch
    ex_ready = 0;
    issue(6'h08, 0, 1, 0, 1, 12);
    tick;
    issue(6'h08, 0, 2, 0, 2, 13);
    tick;
    chk("sd_count_pre", 32'(dut.count), 2);
    ex_ready = 1;
    issue(6'h08, 0, 3, 0, 3, 14);
    tick; issue_en = 0;
    chk("sd_count", 32'(dut.count), 2);
    chk("sd_head_rd", 32'(ex_rd), 13);
    // rdy low freezes everything
    rdy = 0;
    #1 chk("rdy_low_valid", 32'(ex_valid), 0);
    tick;
    chk("rdy_low_count", 32'(dut.count), 2);
    rdy = 1;
    #1 chk("rdy_back_rd", 32'(ex_rd), 13);
    // reset mid-stream
    rst = 1;
    tick; rst = 0;
    chk("mr_count", 32'(dut.count), 0);
    chk("mr_valid", 32'(ex_valid), 0);
    chk("mr_full", 32'(full), 0);
    chk("mr_rd", 32'(ex_rd), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station that sits between the register-status/dispatch stage and the master ALU.
- Accepts issued ops whose operands come from the register-status read ports (data plus producer tag), and snoops the three write-back buses (ALU master, ALU slave, load/store) to capture pending operands.
- Hands the oldest fully-ready op to the ALU over a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries (2..8).
- OP_W, 6, width of the ALU opcode field.
- WORD_W, 32, operand and data width.
- TAG_W, 2, producer-tag width. 0 = UNLOCKED, 1 = ALU_MASTER, 2 = ALU_SALVER, 3 = LOAD_STORE.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; low freezes all state.
- issue_en  in  1  issue request this cycle.
- issue_op  in  OP_W  opcode.
- issue_datax  in  WORD_W  operand A value (valid only when issue_tagx = 0).
- issue_tagx  in  TAG_W  operand A producer tag.
- issue_datay  in  WORD_W  operand B value (valid only when issue_tagy = 0).
- issue_tagy  in  TAG_W  operand B producer tag.
- issue_rd  in  RADDR_W  destination register.
- full  out  1  high when count == DEPTH.
- en_w0  in  1  ALU master write-back valid.
- write_data0  in  WORD_W  ALU master result.
- en_w1  in  1  ALU slave write-back valid.
- write_data1  in  WORD_W  ALU slave result.
- en_wM  in  1  load/store write-back valid.
- write_dataM  in  WORD_W  load/store result.
- ex_valid  out  1  an op is offered to the ALU.
- ex_ready  in  1  ALU accepts the offered op.
- ex_op  out  OP_W  offered opcode.
- ex_a  out  WORD_W  offered operand A.
- ex_b  out  WORD_W  offered operand B.
- ex_rd  out  RADDR_W  offered destination register.

Behaviour:
- Clocking and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - On rst: count = 0 and all entries invalid; full = 0, ex_valid = 0. ex_op, ex_a, ex_b, ex_rd read as 0.
- rdy low (rst low): no state changes, issue and broadcasts ignored, ex_valid forced 0. Wake-ups missed during this time are not recovered; upstream holds buses idle while rdy is low.
- Storage:
  - Compacting age-ordered queue; slot 0 is oldest.
  - Each entry holds op, rd, valx/tagx, valy/tagy.
  - An entry is ready when tagx == 0 and tagy == 0.
- Wake-up, each cycle, for every valid entry and each operand with a nonzero tag:
  - tag 1 and en_w0: capture write_data0, clear tag.
  - tag 2 and en_w1: capture write_data1, clear tag.
  - tag 3 and en_wM: capture write_dataM, clear tag.
  - Captured values are visible to selection the next cycle.
- Issue:
  - If issue_en and count < DEPTH at the edge, append the new entry at slot count (after any compaction).
  - Same-cycle bypass: if an issued operand's tag matches a firing bus, the entry stores that bus data with tag 0.
  - Tag 0 operands store the issue data as-is.
- Issue while full: issue_en with full = 1 is dropped, even if a dispatch fires the same cycle; full reflects the registered count. Dispatch stage must not issue while full is high.
- Selection (combinational):
  - ex_valid = 1 when any valid entry is ready.
  - ex_* carry the lowest-index ready entry (oldest ready); ops may dispatch out of order relative to non-ready older entries.
- Dispatch:
  - On ex_valid && ex_ready at the edge, remove the selected entry, shift higher slots down by one, and decrement count.
  - Simultaneous dispatch and issue: count is unchanged, and the new entry lands at slot count-1.
  - ex_ready with ex_valid = 0 has no effect.
- Latency:
  - Issue with both tags 0 gives ex_valid on the next cycle, provided no older ready entry exists.
  - Broadcast at cycle N makes the entry eligible at N+1.
- Counter widths: count holds 0..DEPTH and never wraps. Reaching DEPTH asserts full at the same edge. Dropping below DEPTH deasserts it at that edge.
- A broadcast with no matching tag has no effect. Multiple buses may fire in one cycle; each operand matches at most one bus, by its tag.

Test Plan:
- Ready issue: rst, then issue op=0x01, tagx=0, datax=5, tagy=0, datay=7, rd=3, with ex_ready=1. Required: ex_valid=1 the next cycle with ex_a=5, ex_b=7, ex_rd=3; entry removed after that edge, count=0.
- Wake-up: issue tagx=3, tagy=0, datay=9, ex_ready=1; 2 cycles later en_wM=1, write_dataM=0x1234. Required: ex_valid=0 until the cycle after the broadcast, then ex_a=0x1234, ex_b=9.
- Bypass: issue tagx=1 in the same cycle as en_w0=1, write_data0=42. Required: ex_valid=1 the next cycle with ex_a=42; no further broadcast needed.
- Out-of-order: issue A (tagx=2, pending), then B (ready). Required: B dispatches first; after en_w1=1, write_data1=8, A dispatches with ex_a=8.
- Full/backpressure: ex_ready=0, issue 4 ready ops. Required: full=1 after the 4th edge; a 5th issue_en is dropped. Raise ex_ready: ops exit in issue order, one per cycle, and full=0 after the first dispatch.
- Simultaneous issue/dispatch and reset: with count=2 and ex_ready=1, issue in the same cycle. Required: count stays 2. Then assert rst mid-stream with rdy=1: next cycle count=0, ex_valid=0, full=0.
